// File: rtl/dds_serial_slave.sv
// dds_serial_slave: responder end of the DDS 3-wire serial port.
// Decodes instruction/data words into a shadow register file and copies
// shadow to active on IO_UPDATE. Ramp and CFR active registers are exported.
// Optional build macro DDS_SLAVE_READBACK_EN: drive read data on sdo/sdo_oe.
module dds_serial_slave #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] CFR2_RST = 32'h00400820,
  parameter logic [31:0] CFR3_RST = 32'h1F3F4000
) (
  input  logic        fifty_MHz_intclk,
  input  logic        sys_reset,
  input  logic        SCLK,
  input  logic        SDIO,
  input  logic        CSB,
  input  logic        IO_RESET,
  input  logic        IO_UPDATE,
  output logic        sdo,
  output logic        sdo_oe,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic        update_pulse,
  output logic        addr_err,
  output logic [31:0] cfr1,
  output logic [31:0] cfr2,
  output logic [31:0] cfr3,
  output logic [63:0] ramp_limits,
  output logic [63:0] ramp_step,
  output logic [31:0] ramp_rate
);

  // Synchroniser order: {SCLK, SDIO, CSB, IO_RESET, IO_UPDATE}; CSB idles high.
  localparam logic [4:0] SYNC_IDLE = 5'b00100;

  typedef enum logic [1:0] {IDLE, INSTR, WDATA, RDATA} state_t;

  state_t      state, state_n;
  logic [4:0]  sync1, sync2;
  logic        sclk_prev, upd_prev;
  logic        sclk_s, sdio_s, csb_s, iorst_s, upd_s;
  logic        sclk_rise, upd_rise, last_bit;
  logic [63:0] data_sr;
  logic [6:0]  bit_cnt;
  logic [4:0]  cur_addr, instr_addr;
  logic        cur_len64, instr_len64, instr_rd;
  logic        commit_pend, commit_store;
  logic [63:0] commit_data;
  logic [63:0] shadow [NUM_REGS];
  logic [63:0] active [NUM_REGS];

  function automatic logic [63:0] reg_rst(input int unsigned idx);
    case (idx)
      1:       reg_rst = {32'h0, CFR2_RST};
      2:       reg_rst = {32'h0, CFR3_RST};
      default: reg_rst = '0;
    endcase
  endfunction

  // Two-flop synchronisers plus previous-value flops for edge detection.
  always_ff @(posedge fifty_MHz_intclk or posedge sys_reset) begin
    if (sys_reset) begin
      sync1     <= SYNC_IDLE;
      sync2     <= SYNC_IDLE;
      sclk_prev <= 1'b0;
      upd_prev  <= 1'b0;
    end else begin
      sync1     <= {SCLK, SDIO, CSB, IO_RESET, IO_UPDATE};
      sync2     <= sync1;
      sclk_prev <= sync2[4];
      upd_prev  <= sync2[0];
    end
  end

  assign sclk_s    = sync2[4];
  assign sdio_s    = sync2[3];
  assign csb_s     = sync2[2];
  assign iorst_s   = sync2[1];
  assign upd_s     = sync2[0];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign upd_rise  = upd_s & ~upd_prev;
  assign last_bit  = sclk_rise && (bit_cnt == 7'd1);

  // Instruction fields as they stand while the 8th instruction bit is sampled.
  assign instr_addr  = {data_sr[3:0], sdio_s};
  assign instr_rd    = data_sr[6];
  assign instr_len64 = (instr_addr == 5'h0B) || (instr_addr == 5'h0C) || (instr_addr >= 5'h0E);

  // FSM state register.
  always_ff @(posedge fifty_MHz_intclk or posedge sys_reset) begin
    if (sys_reset) state <= IDLE;
    else           state <= state_n;
  end

  // Next state: CSB high beats IO_RESET, which beats bit counting.
  always_comb begin
    state_n = state;
    if (csb_s) begin
      state_n = IDLE;
    end else if (state == IDLE || iorst_s) begin
      state_n = INSTR;
    end else if (last_bit) begin
      if (state == INSTR) state_n = instr_rd ? RDATA : WDATA;
      else                state_n = INSTR;
    end
  end

  // Shift register, bit counter and instruction capture; flags a completed write.
  always_ff @(posedge fifty_MHz_intclk or posedge sys_reset) begin
    if (sys_reset) begin
      data_sr     <= '0;
      bit_cnt     <= 7'd8;
      cur_addr    <= '0;
      cur_len64   <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      if (csb_s || iorst_s || state == IDLE) begin
        bit_cnt <= 7'd8;
      end else if (sclk_rise) begin
        if (state != RDATA) data_sr <= {data_sr[62:0], sdio_s};
        if (bit_cnt == 7'd1) begin
          if (state == INSTR) begin
            cur_addr  <= instr_addr;
            cur_len64 <= instr_len64;
            bit_cnt   <= instr_len64 ? 7'd64 : 7'd32;
          end else begin
            bit_cnt     <= 7'd8;
            commit_pend <= (state == WDATA);
          end
        end else begin
          bit_cnt <= bit_cnt - 7'd1;
        end
      end
    end
  end

  // 32-bit words sit in the low half; the upper half of the shifter holds stale bits.
  assign commit_data  = cur_len64 ? data_sr : {32'h0, data_sr[31:0]};
  assign commit_store = commit_pend && (32'(cur_addr) < NUM_REGS);

  // Shadow commit and shadow-to-active transfer, bypassing a same-cycle commit.
  always_ff @(posedge fifty_MHz_intclk or posedge sys_reset) begin
    if (sys_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= reg_rst(i);
        active[i] <= reg_rst(i);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit_store && 32'(cur_addr) == i) shadow[i] <= commit_data;
        if (upd_rise)
          active[i] <= (commit_store && 32'(cur_addr) == i) ? commit_data : shadow[i];
      end
    end
  end

  // Commit strobe, last address, sticky address error and update pulse.
  always_ff @(posedge fifty_MHz_intclk or posedge sys_reset) begin
    if (sys_reset) begin
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      addr_err     <= 1'b0;
      update_pulse <= 1'b0;
    end else begin
      wr_strobe    <= commit_pend;
      update_pulse <= upd_rise;
      if (commit_pend) begin
        wr_addr <= cur_addr;
        if (32'(cur_addr) >= NUM_REGS) addr_err <= 1'b1;
      end
    end
  end

  assign cfr1        = active[0][31:0];
  assign cfr2        = active[1][31:0];
  assign cfr3        = active[2][31:0];
  assign ramp_limits = active[11];
  assign ramp_step   = active[12];
  assign ramp_rate   = active[13][31:0];

`ifdef DDS_SLAVE_READBACK_EN
  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [63:0] rd_sr, rd_word;
  logic        sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_prev;

  // Read word from shadow, MSB-aligned; unstored addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (32'(instr_addr) < NUM_REGS) rd_word = shadow[instr_addr[AW-1:0]];
    if (!instr_len64) rd_word = {rd_word[31:0], 32'h0};
  end

  // Load on instruction completion, shift on each SCLK falling edge while reading.
  always_ff @(posedge fifty_MHz_intclk or posedge sys_reset) begin
    if (sys_reset)                              rd_sr <= '0;
    else if (state == INSTR && state_n == RDATA) rd_sr <= rd_word;
    else if (state == RDATA && sclk_fall)        rd_sr <= {rd_sr[62:0], 1'b0};
  end

  assign sdo    = (state == RDATA) & rd_sr[63];
  assign sdo_oe = (state == RDATA);
`else
  assign sdo    = 1'b0;
  assign sdo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_dds_serial_slave.sv
// Directed bench for dds_serial_slave: table of write/update vectors plus
// hand sequences for multi-word frames, aborts, timing, bypass, readback, reset.
module tb_dds_serial_slave;

  logic        clk = 1'b0, rst = 1'b1;
  logic        SCLK = 1'b0, SDIO = 1'b0, CSB = 1'b1, IO_RESET = 1'b0, IO_UPDATE = 1'b0;
  logic        sdo, sdo_oe, wr_strobe, update_pulse, addr_err;
  logic [4:0]  wr_addr;
  logic [31:0] cfr1, cfr2, cfr3, ramp_rate;
  logic [63:0] ramp_limits, ramp_step;

  always #10 clk = ~clk;

  dds_serial_slave #(.NUM_REGS(16), .CFR2_RST(32'h00400820), .CFR3_RST(32'h1F3F4000)) dut (
    .fifty_MHz_intclk(clk), .sys_reset(rst),
    .SCLK(SCLK), .SDIO(SDIO), .CSB(CSB), .IO_RESET(IO_RESET), .IO_UPDATE(IO_UPDATE),
    .sdo(sdo), .sdo_oe(sdo_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .update_pulse(update_pulse), .addr_err(addr_err),
    .cfr1(cfr1), .cfr2(cfr2), .cfr3(cfr3),
    .ramp_limits(ramp_limits), .ramp_step(ramp_step), .ramp_rate(ramp_rate)
  );

  typedef struct {
    logic [31:0] c1, c2, c3;
    logic [63:0] rl, rs;
    logic [31:0] rr;
    logic        ae;
  } exp_t;

  typedef struct {
    logic [7:0]  instr;
    logic [63:0] data;
    int          nbits;
    logic [4:0]  addr;
    exp_t        exp;
  } vec_t;

  int         n_checks = 0, n_fail = 0, upd_cnt = 0;
  logic [4:0] wq[$];

  // Record every commit strobe and update pulse.
  always @(negedge clk) begin
    if (wr_strobe)    wq.push_back(wr_addr);
    if (update_pulse) upd_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".cfr1"}, 64'(cfr1), 64'(e.c1));
    chk({tag, ".cfr2"}, 64'(cfr2), 64'(e.c2));
    chk({tag, ".cfr3"}, 64'(cfr3), 64'(e.c3));
    chk({tag, ".ramp_limits"}, ramp_limits, e.rl);
    chk({tag, ".ramp_step"}, ramp_step, e.rs);
    chk({tag, ".ramp_rate"}, 64'(ramp_rate), 64'(e.rr));
    chk({tag, ".addr_err"}, 64'(addr_err), 64'(e.ae));
  endtask

  // One SCLK period: low 2 clocks with data set up, then high.
  task automatic sclk_bit(input logic b);
    @(negedge clk); SCLK = 1'b0; SDIO = b;
    repeat (2) @(negedge clk);
    SCLK = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_bit(v[i]);
  endtask

  task automatic frame_begin();
    @(negedge clk); CSB = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (3) @(negedge clk);
    SCLK = 1'b0; CSB = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic write_frame(input logic [7:0] instr, input logic [63:0] data, input int n);
    frame_begin();
    send_word(64'(instr), 8);
    send_word(data, n);
    frame_end();
  endtask

  task automatic pulse_update();
    @(negedge clk); IO_UPDATE = 1'b1;
    repeat (4) @(negedge clk);
    IO_UPDATE = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vec[8];
    exp_t        rst_exp, e, cur, pre;
    int          u0;
    logic [31:0] w, rb;
    logic        exp_oe;

    rst_exp = '{c1: 32'h0, c2: 32'h00400820, c3: 32'h1F3F4000, rl: 64'h0, rs: 64'h0, rr: 32'h0, ae: 1'b0};
    e = rst_exp;
    e.rl = 64'h26666666_00000000; vec[0] = '{8'h0B, 64'h26666666_00000000, 64, 5'h0B, e};
    e.c1 = 32'h00010002;          vec[1] = '{8'h00, 64'h00010002, 32, 5'h00, e};
    e.c2 = 32'h01400820;          vec[2] = '{8'h01, 64'h01400820, 32, 5'h01, e};
    e.rr = 32'h0000BEEF;          vec[3] = '{8'h6D, 64'h0000BEEF, 32, 5'h0D, e};
                                  vec[4] = '{8'h05, 64'h12345678, 32, 5'h05, e};
                                  vec[5] = '{8'h0E, 64'h01234567_89ABCDEF, 64, 5'h0E, e};
    e.ae = 1'b1;                  vec[6] = '{8'h1F, 64'hFFFFFFFF_FFFFFFFF, 64, 5'h1F, e};
    e.c3 = 32'hCAFEF00D;          vec[7] = '{8'h02, 64'hCAFEF00D, 32, 5'h02, e};

    // Reset state.
    repeat (3) @(negedge clk);
    check_outs("reset", rst_exp);
    chk("reset.wr_strobe", 64'(wr_strobe), 64'd0);
    chk("reset.update_pulse", 64'(update_pulse), 64'd0);
    chk("reset.wr_addr", 64'(wr_addr), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_outs("after_reset", rst_exp);

    // Table: one write per frame, then IO_UPDATE.
    cur = rst_exp;
    for (int v = 0; v < 8; v++) begin
      pre = cur; pre.ae = vec[v].exp.ae;
      wq.delete();
      write_frame(vec[v].instr, vec[v].data, vec[v].nbits);
      chk($sformatf("vec%0d_wr_count", v), 64'(wq.size()), 64'd1);
      if (wq.size() > 0) chk($sformatf("vec%0d_wr_addr", v), 64'(wq[0]), 64'(vec[v].addr));
      check_outs($sformatf("vec%0d_pre", v), pre);
      u0 = upd_cnt;
      pulse_update();
      chk($sformatf("vec%0d_update_count", v), 64'(upd_cnt - u0), 64'd1);
      check_outs($sformatf("vec%0d_post", v), vec[v].exp);
      cur = vec[v].exp;
    end

    // Two instructions in one CSB frame, one transfer.
    wq.delete();
    frame_begin();
    send_word(64'h0C, 8); send_word(64'hFFFFFFFF_0000000A, 64);
    send_word(64'h0D, 8); send_word(64'h0001003B, 32);
    frame_end();
    chk("multi_wr_count", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("multi_wr_addr0", 64'(wq[0]), 64'h0C);
      chk("multi_wr_addr1", 64'(wq[1]), 64'h0D);
    end
    chk("multi_pre_step", ramp_step, 64'h0);
    chk("multi_pre_rate", 64'(ramp_rate), 64'h0000BEEF);
    u0 = upd_cnt;
    pulse_update();
    chk("multi_update_count", 64'(upd_cnt - u0), 64'd1);
    chk("multi_step", ramp_step, 64'hFFFFFFFF_0000000A);
    chk("multi_rate", 64'(ramp_rate), 64'h0001003B);

    // CSB abort after 20 data bits.
    wq.delete();
    frame_begin();
    send_word(64'h0D, 8); send_word(64'hABCDE, 20);
    frame_end();
    chk("csb_abort_wr_count", 64'(wq.size()), 64'd0);
    pulse_update();
    chk("csb_abort_rate", 64'(ramp_rate), 64'h0001003B);
    write_frame(8'h0D, 64'h00000777, 32);
    chk("csb_next_wr_count", 64'(wq.size()), 64'd1);
    pulse_update();
    chk("csb_next_rate", 64'(ramp_rate), 64'h00000777);

    // IO_RESET abort with CSB held low, then a fresh instruction.
    wq.delete();
    frame_begin();
    send_word(64'h0D, 8); send_word(64'hABCDE, 20);
    @(negedge clk); IO_RESET = 1'b1;
    repeat (4) @(negedge clk);
    IO_RESET = 1'b0;
    repeat (4) @(negedge clk);
    send_word(64'h0D, 8); send_word(64'h00000999, 32);
    frame_end();
    chk("iorst_wr_count", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("iorst_wr_addr", 64'(wq[0]), 64'h0D);
    pulse_update();
    chk("iorst_rate", 64'(ramp_rate), 64'h00000999);

    // Strobe latency and commit/update coincidence (bypass).
    w = 32'h00000ABD;
    frame_begin();
    send_word(64'h0D, 8); send_word(64'(w >> 1), 31);
    @(negedge clk); SCLK = 1'b0; SDIO = w[0];
    repeat (2) @(negedge clk);
    SCLK = 1'b1;
    @(negedge clk); IO_UPDATE = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("latency_strobe_early", 64'(wr_strobe), 64'd0);
    chk("latency_rate_early", 64'(ramp_rate), 64'h00000999);
    @(negedge clk);
    chk("latency_strobe", 64'(wr_strobe), 64'd1);
    chk("latency_wr_addr", 64'(wr_addr), 64'h0D);
    chk("bypass_update_pulse", 64'(update_pulse), 64'd1);
    chk("bypass_rate", 64'(ramp_rate), 64'h00000ABD);
    @(negedge clk);
    chk("strobe_one_cycle", 64'(wr_strobe), 64'd0);
    chk("update_one_cycle", 64'(update_pulse), 64'd0);
    IO_UPDATE = 1'b0;
    frame_end();

    // Held-high IO_UPDATE transfers once.
    write_frame(8'h0D, 64'h55, 32);
    u0 = upd_cnt;
    @(negedge clk); IO_UPDATE = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_update_count", 64'(upd_cnt - u0), 64'd1);
    chk("held_rate", 64'(ramp_rate), 64'h55);
    write_frame(8'h0D, 64'h66, 32);
    chk("held_no_retransfer", 64'(ramp_rate), 64'h55);
    IO_UPDATE = 1'b0;
    repeat (4) @(negedge clk);
    pulse_update();
    chk("held_release_rate", 64'(ramp_rate), 64'h66);

    // Read of address 0x02 after writing A5A5A5A5.
`ifdef DDS_SLAVE_READBACK_EN
    rb = 32'hA5A5A5A5; exp_oe = 1'b1;
`else
    rb = 32'h0; exp_oe = 1'b0;
`endif
    write_frame(8'h02, 64'hA5A5A5A5, 32);
    wq.delete();
    frame_begin();
    send_word(64'h82, 8);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk); SCLK = 1'b0; SDIO = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("read_sdo_bit%0d", 31 - k), 64'(sdo), 64'(rb[31 - k]));
      chk($sformatf("read_oe_bit%0d", 31 - k), 64'(sdo_oe), 64'(exp_oe));
      SCLK = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("read_oe_after", 64'(sdo_oe), 64'd0);
    chk("read_sdo_after", 64'(sdo), 64'd0);
    frame_end();
    chk("read_wr_count", 64'(wq.size()), 64'd0);
    pulse_update();
    chk("read_cfr3", 64'(cfr3), 64'hA5A5A5A5);

    // Reset mid-stream during a 64-bit write.
    frame_begin();
    send_word(64'h0B, 8); send_word(64'h3FF, 10);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_outs("midreset", rst_exp);
    chk("midreset.wr_strobe", 64'(wr_strobe), 64'd0);
    chk("midreset.update_pulse", 64'(update_pulse), 64'd0);
    chk("midreset.wr_addr", 64'(wr_addr), 64'd0);
    chk("midreset.sdo_oe", 64'(sdo_oe), 64'd0);
    CSB = 1'b1; SCLK = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wq.delete();
    write_frame(8'h0C, 64'h1, 64);
    chk("postreset_wr_count", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("postreset_wr_addr", 64'(wq[0]), 64'h0C);
    pulse_update();
    chk("postreset_step", ramp_step, 64'h1);
    chk("postreset_limits", ramp_limits, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_serial_slave.md
Name: dds_serial_slave

Overview:
- Responder end of the DDS 3-wire serial port: decodes the SDIO/SCLK/CSB/IO_RESET/IO_UPDATE stream produced by our DDS control masters.
- Holds a shadow (buffer) register file and an active register file; IO_UPDATE transfers shadow to active.
- Used as a loopback DDS model for bench and on-board self-check of init/sweep sequences. Exposes ramp and CFR registers to monitor logic.

Parameters:
- NUM_REGS, 16, register addresses 0..NUM_REGS-1 stored; higher addresses are decoded but not stored.
- CFR2_RST, 32'h00400820, reset value of CFR2 (address 0x01), shadow and active.
- CFR3_RST, 32'h1F3F4000, reset value of CFR3 (address 0x02), shadow and active.

Ports:
- fifty_MHz_intclk  in  1  system clock; all logic on its rising edge.
- sys_reset  in  1  asynchronous, active-high reset.
- SCLK  in  1  serial clock from master.
- SDIO  in  1  serial data from master.
- CSB  in  1  chip select, active low.
- IO_RESET  in  1  serial-port resync, active high.
- IO_UPDATE  in  1  shadow-to-active transfer, rising edge.
- sdo  out  1  read data.
- sdo_oe  out  1  high while sdo is driven.
- wr_strobe  out  1  one-cycle pulse when a shadow word commits.
- wr_addr  out  5  address of the last committed word.
- update_pulse  out  1  one-cycle pulse on each IO_UPDATE transfer.
- addr_err  out  1  sticky: write to an unstored address; cleared only by sys_reset.
- cfr1, cfr2, cfr3  out  32 each  active registers at 0x00, 0x01, 0x02.
- ramp_limits  out  64  active register 0x0B.
- ramp_step  out  64  active register 0x0C.
- ramp_rate  out  32  active register 0x0D.

Behaviour:
- Input synchronisation:
  - SCLK, SDIO, CSB, IO_RESET and IO_UPDATE each pass through a 2-flop synchroniser, then edge detection.
  - Minimum SCLK high or low time is 1 clock.
  - Data is sampled on the synchronised SCLK rising edge.
- Word length is looked up by address. 32 bits: 0x00-0x0A and 0x0D. 64 bits: 0x0B, 0x0C, 0x0E-0x1F.
- Instruction byte, MSB first: bit7 = R/W (1 = read), bits 6:5 ignored, bits 4:0 = address. Data follows MSB first.
- FSM states and transitions:
  - IDLE: CSB high. CSB low -> INSTR.
  - INSTR: after 8 bits -> WDATA or RDATA; bit counter loaded with the word length.
  - WDATA / RDATA: after the last bit -> INSTR while CSB stays low, so multiple instructions stream in one CSB frame.
  - CSB high in any state -> IDLE; the partial word is discarded and shadow is unchanged.
  - IO_RESET high in any state other than IDLE -> INSTR; the partial word is discarded. CSB high takes priority over IO_RESET.
- Write commit:
  - The whole word is written to shadow on the cycle after its last bit is sampled; partial words are never written.
  - wr_strobe and wr_addr are valid 4 clocks after the pin-level SCLK rising edge of the last bit.
  - For address >= NUM_REGS: no store, wr_strobe still pulses, addr_err is set.
  - 32-bit registers occupy the low 32 bits of their 64-bit storage.
- IO_UPDATE:
  - On the synchronised rising edge, all of active <= shadow, and update_pulse asserts in the same cycle.
  - If a commit coincides with the transfer, active receives the newly committed value (bypass).
  - A held-high IO_UPDATE causes no repeated transfer.
- Reset (asynchronous) values:
  - Shadow and active: CFR1 = 0, CFR2 = CFR2_RST, CFR3 = CFR3_RST, all other registers 0.
  - All outputs 0 except cfr2 and cfr3, which take their reset values.
  - FSM in IDLE.

Optional Feature:
- Macro: DDS_SLAVE_READBACK_EN.
- Defined:
  - A read instruction shifts the shadow word out on sdo, MSB first.
  - The MSB is driven on the cycle the instruction completes; sdo advances on each synchronised SCLK falling edge.
  - sdo_oe is high for the entire RDATA state.
  - Addresses >= NUM_REGS read as 0.
- Undefined:
  - RDATA consumes the word-length clocks without driving; sdo and sdo_oe are held at 0.
  - Shadow is never modified by a read.

Test Plan:
- Reset mid-stream: assert sys_reset during WDATA -> cfr2 = 32'h00400820, cfr3 = 32'h1F3F4000, ramp outputs 0, all strobes 0, FSM in IDLE.
- Write 8'h0B + 64'h26666666_00000000, then IO_UPDATE -> wr_strobe with wr_addr = 0x0B; ramp_limits unchanged until update_pulse, then = 64'h26666666_00000000.
- One CSB frame carrying 0x0C (64'hFFFFFFFF_0000000A) then 0x0D (32'h0001003B), then IO_UPDATE -> two wr_strobes (addresses 0x0C, 0x0D); ramp_step and ramp_rate both load on one update_pulse.
- CSB high after 20 data bits of a 0x0D write -> no wr_strobe, shadow unchanged; the next frame with instruction 0x0D decodes correctly. Repeat the abort using IO_RESET with CSB held low -> same outcome.
- Write to address 0x1F -> wr_strobe with wr_addr = 0x1F, addr_err set, no stored state changes.
- With DDS_SLAVE_READBACK_EN: write 0x02 = 32'hA5A5A5A5, then read 8'h82 -> sdo shifts A5A5A5A5 MSB first with sdo_oe high for exactly 32 SCLKs. Without the macro: sdo = 0 and sdo_oe = 0 throughout the read.
